// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: drives ICG enable from activity, force_on and wake handshake; idle-window gating with gating-event count
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              activity,
  input  logic              force_on,
  input  logic              wake_req,
  output logic              wake_ack,
  output logic              gate_en,
  output logic              gated,
  output logic [STAT_W-1:0] gate_count
);
  typedef enum logic [1:0] {ACTIVE, GATED, WAKE} state_t;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic keep;
  assign keep = activity | force_on | wake_req;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      ACTIVE: begin
        state_n = !keep && cnt == IDLE_LAST ? GATED : ACTIVE;
        cnt_n = keep || cnt == IDLE_LAST ? '0 : cnt + 1'b1;
      end
      GATED: begin
        state_n = keep ? WAKE : GATED;
        cnt_n = '0;
      end
      WAKE: begin
        state_n = cnt == WAKE_LAST ? ACTIVE : WAKE;
        cnt_n = cnt == WAKE_LAST ? '0 : cnt + 1'b1;
      end
      default: begin
        state_n = ACTIVE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= ACTIVE;
      cnt <= '0;
      gate_en <= 1'b1;
      gated <= 1'b0;
      wake_ack <= 1'b0;
      gate_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gate_en <= state_n != GATED;
      gated <= state_n == GATED;
      wake_ack <= state == ACTIVE && wake_req;
      gate_count <= state == ACTIVE && state_n == GATED && !(&gate_count) ? gate_count + 1'b1 : gate_count;
    end
  end
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb_clock_gate_ctrl: randomized and directed scoreboard bench for clock_gate_ctrl
module tb_clock_gate_ctrl;
  localparam int IDLE = 16;
  localparam int WAKE = 2;
  localparam int STAT_W = 4;
  localparam int SAT = (1 << STAT_W) - 1;
  typedef struct packed {
    logic en;
    logic gd;
    logic ack;
    logic [STAT_W-1:0] cnt;
  } exp_t;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic activity = 1'b0;
  logic force_on = 1'b0;
  logic wake_req = 1'b0;
  logic wake_ack, gate_en, gated;
  logic [STAT_W-1:0] gate_count;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int step = 0;
  bit m_gated = 1'b0;
  int m_idle = 0;
  int m_wake = 0;
  int m_count = 0;
  clock_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(8), .STAT_W(STAT_W)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .activity(activity),
    .force_on(force_on),
    .wake_req(wake_req),
    .wake_ack(wake_ack),
    .gate_en(gate_en),
    .gated(gated),
    .gate_count(gate_count)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in or posedge rst) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      step++;
      n_chk++;
      if (gate_en !== e.en || gated !== e.gd || wake_ack !== e.ack || gate_count !== e.cnt) begin
        n_fail++;
        $display("FAIL step%0d outputs en/gated/ack/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 step, gate_en, gated, wake_ack, gate_count, e.en, e.gd, e.ack, e.cnt);
      end
    end
  end
  function automatic exp_t model_reset();
    m_gated = 1'b0;
    m_idle = 0;
    m_wake = 0;
    m_count = 0;
    return '{en: 1'b1, gd: 1'b0, ack: 1'b0, cnt: '0};
  endfunction
  // Effect of one clock edge with the given inputs sampled, in terms of idle run, wake countdown, gated flag.
  function automatic exp_t model_step(bit a, bit f, bit w);
    bit keep = a | f | w;
    bit ack = w && !m_gated && m_wake == 0;
    if (m_gated) begin
      if (keep) begin
        m_gated = 1'b0;
        m_wake = WAKE;
      end
    end else if (m_wake > 0) begin
      m_wake--;
    end else begin
      m_idle = keep ? 0 : m_idle + 1;
      if (m_idle == IDLE) begin
        m_gated = 1'b1;
        m_idle = 0;
        m_count = m_count < SAT ? m_count + 1 : SAT;
      end
    end
    return '{en: !m_gated, gd: m_gated, ack: ack, cnt: STAT_W'(m_count)};
  endfunction
  task automatic cyc(bit r, bit a, bit f, bit w);
    @(negedge clk_in);
    rst = r;
    activity = a;
    force_on = f;
    wake_req = w;
    q.push_back(r ? model_reset() : model_step(a, f, w));
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask
  task automatic areset();
    exp_t e;
    @(negedge clk_in);
    #2;
    e = model_reset();
    q.push_back(e);
    q.push_back(e);
    rst = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    idle(15);
    cyc(0, 1, 0, 0);
    idle(20);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    idle(20);
    for (int i = 0; i < 100; i++) cyc(0, 0, 1, 0);
    idle(20);
    areset();
    idle(17);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    areset();
    for (int k = 0; k < 20; k++) begin
      idle(17);
      cyc(0, 1, 0, 0);
      idle(2);
    end
    for (int i = 0; i < 2000; i++) begin
      bit a = $urandom_range(0, 24) == 0;
      bit f = $urandom_range(0, 60) == 0;
      bit w = $urandom_range(0, 40) == 0;
      if ($urandom_range(0, 400) == 0) areset();
      cyc(0, a, f, w);
    end
    idle(3);
    @(negedge clk_in);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue_left got %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
- Enable-side controller that drives the `enable` input of a `clock_gating_cell` / `clock_gating_cell_no_test` instance for one DSP clock domain.
- Watches domain activity, removes the clock after a programmable idle window, and restores it on activity, software force, or a four-phase wake request/acknowledge handshake.
- Runs on the ungated source clock (the ICG's `clk_in`), never on the gated output.

Parameters:
- IDLE_CYCLES, 16: consecutive idle cycles before gating; legal range 1..2^CNT_W-1.
- WAKE_CYCLES, 2: running-clock cycles after ungating before the block is considered awake; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the internal idle/wake counter.
- STAT_W, 16: width of the gating-event counter.

Ports:
- clk_in  input  1  ungated source clock.
- rst  input  1  asynchronous, active-high reset.
- activity  input  1  domain busy/pending-work indication, level.
- force_on  input  1  software override; keeps clock running while high.
- wake_req  input  1  four-phase wake request from a neighbouring domain.
- wake_ack  output  1  wake acknowledge; registered.
- gate_en  output  1  to ICG `enable`; registered; 1 = clock running.
- gated  output  1  status; registered; 1 while clock is removed.
- gate_count  output  STAT_W  saturating count of entries into GATED.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=ACTIVE, gate_en=1, gated=0, wake_ack=0, gate_count=0, counter=0.
  - Mid-operation assertion from any state gives the same values immediately.
- keep = activity | force_on | wake_req.
- ACTIVE:
  - gate_en=1.
  - keep=1: counter<=0.
  - keep=0: counter increments.
  - Transition: keep=0 and counter==IDLE_CYCLES-1 -> GATED. Effect: gate_en=0 and gated=1 on the edge that ends the IDLE_CYCLES-th consecutive idle cycle.
  - Any keep=1 cycle restarts the window.
- GATED:
  - gate_en=0, gated=1.
  - On entry: gate_count increments, holding at all-ones.
  - keep=1 -> WAKE: gate_en=1 and gated=0 on the next edge; counter<=0.
- WAKE:
  - gate_en=1.
  - Counter increments every cycle regardless of keep.
  - counter==WAKE_CYCLES-1 -> ACTIVE with counter<=0.
  - No re-gating is allowed from WAKE.
- wake_ack (registered):
  - Rises the edge after a cycle where state==ACTIVE and wake_req=1.
  - Falls the edge after wake_req=0.
  - Never asserted in GATED or WAKE.
  - From GATED, ack latency = 1 (enter WAKE) + WAKE_CYCLES + 1 cycles after wake_req rises.
- Simultaneous events:
  - keep rising in the same cycle that the idle counter reaches the threshold: keep wins; no gating; counter cleared.
  - wake_req dropping during WAKE: WAKE completes; then normal idle counting.
- Glitch freedom: all outputs are flop outputs; gate_en changes only on clk_in rising edges. The ICG latch handles timing of the enable.
- Arithmetic: counter width CNT_W, no wrap in legal use. gate_count saturates at 2^STAT_W-1 and never wraps.

Test Plan:
- Reset then all inputs 0, IDLE_CYCLES=16 -> gate_en=1 for 16 cycles, falls on 16th edge; gated=1; gate_count=1.
- Idle 15 cycles, activity pulse 1 cycle, idle -> no gating until 16 further idle cycles; gate_count remains 0 until then.
- Gated, wake_req raised, WAKE_CYCLES=2 -> gate_en=1 next edge; wake_ack=1 four edges after request; wake_req low -> wake_ack=0 next edge; gating resumes 16 idle cycles later.
- Gated, force_on held 100 cycles -> gate_en=1 throughout after 1 cycle; no re-gating; gate_count unchanged.
- rst asserted mid-WAKE and mid-GATED (asynchronously, between edges) -> gate_en=1, gated=0, wake_ack=0, gate_count=0 immediately.
- STAT_W=4, 20 gate/wake cycles -> gate_count saturates at 15.
